conv_args_reg_loader: RTL and testbench

- Downstream consumer of the conv args controller. Captures bias/tail/rank buffer read data (one argument type per instance) into a ping-pong argument register file feeding the post-processing lanes.
- Slices each wide buffer word into per-register arguments using the controller's reg_start/reg_size.
- Fills a shadow bank while the active bank is used, then swaps banks on request.

---
 rtl/conv_args_reg_loader.sv | 125 ++++++++++++
 tb/tb_conv_args_reg_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_args_reg_loader.sv
// Ping-pong argument register file: slices bias/tail/rank buffer words into a
// shadow bank, then hands the shadow bank to the post-processing lanes on swap.
module conv_args_reg_loader #(
    parameter int ARG_W          = 16,
    parameter int WORD_ARGS_2POW = 6,
    parameter int REG_NUM        = 64,
    parameter int REG_W          = 32
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    mode,
    input  logic                                    args_refresh,
    input  logic                                    buf_rd,
    input  logic [7:0]                              reg_start,
    input  logic [7:0]                              reg_size,
    input  logic [(2**WORD_ARGS_2POW)*ARG_W-1:0]    buf_dout,
    input  logic                                    args_swap,
    output logic                                    args_swap_ack,
    output logic                                    load_done,
    output logic                                    shadow_full,
    output logic                                    args_valid,
    output logic [REG_NUM*REG_W-1:0]                args_out
);
    localparam int IDX_W = WORD_ARGS_2POW;

    logic [REG_NUM-1:0][REG_W-1:0] shadow;
    logic [REG_NUM-1:0][REG_W-1:0] shadow_nxt;
    logic [REG_NUM-1:0][REG_W-1:0] active;

    logic [IDX_W-1:0] src_base;
    logic [IDX_W-1:0] base_now;
    logic [IDX_W-1:0] st_base;
    logic [7:0]       st_start;
    logic [7:0]       st_size;
    logic             st_mode;
    logic             pend;
    logic             wr_en;
    logic             wr_complete;
    logic             swap_fire;
    logic [8:0]       size_p1;
    logic [8:0]       adv;
    logic [7:0]       offs;
    logic [IDX_W-1:0] offs_lo;
    logic [IDX_W-1:0] e0;
    logic [IDX_W-1:0] e1;

    function automatic logic [ARG_W-1:0] elem(input logic [IDX_W-1:0] idx);
        return buf_dout[idx*ARG_W +: ARG_W];
    endfunction

    // A refresh in the same cycle as buf_rd restarts the element stream at 0.
    assign base_now = args_refresh ? '0 : src_base;
    assign size_p1  = {1'b0, reg_size} + 9'd1;
    assign adv      = mode ? {size_p1[7:0], 1'b0} : size_p1;

    // A refresh while a read is in flight aborts that read's write.
    assign wr_en       = pend && !args_refresh;
    assign wr_complete = wr_en && (({1'b0, st_start} + {1'b0, st_size}) >= 9'(REG_NUM - 1));

    // Swap handshake: the consumer holds args_swap high until args_swap_ack
    // pulses; the swap is taken only when the shadow bank is complete and no
    // completing write lands on the same edge.
    assign swap_fire = args_swap && shadow_full && !wr_complete;

    always_comb begin
        shadow_nxt = shadow;
        offs       = '0;
        offs_lo    = '0;
        e0         = '0;
        e1         = '0;
        for (int k = 0; k < REG_NUM; k++) begin
            offs    = 8'(k) - st_start;
            offs_lo = offs[IDX_W-1:0];
            e0      = st_base + (st_mode ? {offs_lo[IDX_W-2:0], 1'b0} : offs_lo);
            e1      = e0 + IDX_W'(1);
            // Destinations past REG_NUM never match k, so they drop out.
            if (wr_en && (8'(k) >= st_start) && (offs <= st_size)) begin
                shadow_nxt[k] = st_mode ? {elem(e1), elem(e0)} : {ARG_W'(0), elem(e0)};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow        <= '0;
            active        <= '0;
            src_base      <= '0;
            st_base       <= '0;
            st_start      <= '0;
            st_size       <= '0;
            st_mode       <= 1'b0;
            pend          <= 1'b0;
            load_done     <= 1'b0;
            args_swap_ack <= 1'b0;
            shadow_full   <= 1'b0;
            args_valid    <= 1'b0;
        end else begin
            pend <= buf_rd;
            if (buf_rd) begin
                st_start <= reg_start;
                st_size  <= reg_size;
                st_mode  <= mode;
                st_base  <= base_now;
                src_base <= base_now + adv[IDX_W-1:0];
            end else if (args_refresh) begin
                src_base <= '0;
            end
            shadow        <= shadow_nxt;
            load_done     <= wr_complete;
            args_swap_ack <= swap_fire;
            if (swap_fire) begin
                active     <= shadow;
                args_valid <= 1'b1;
            end
            if (swap_fire || args_refresh) begin
                shadow_full <= 1'b0;
            end else if (wr_complete) begin
                shadow_full <= 1'b1;
            end
        end
    end

    assign args_out = active;

endmodule

// File: tb/tb_conv_args_reg_loader.sv
// Directed bench for conv_args_reg_loader: hand-computed register contents,
// pulse timing and reset behaviour.
module tb_conv_args_reg_loader;
    logic          clk;
    logic          reset;
    logic          mode;
    logic          args_refresh;
    logic          buf_rd;
    logic [7:0]    reg_start;
    logic [7:0]    reg_size;
    logic [1023:0] buf_dout;
    logic          args_swap;
    logic          args_swap_ack;
    logic          load_done;
    logic          shadow_full;
    logic          args_valid;
    logic [2047:0] args_out;

    int vectors;
    int miscompares;

    conv_args_reg_loader dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .args_refresh (args_refresh),
        .buf_rd       (buf_rd),
        .reg_start    (reg_start),
        .reg_size     (reg_size),
        .buf_dout     (buf_dout),
        .args_swap    (args_swap),
        .args_swap_ack(args_swap_ack),
        .load_done    (load_done),
        .shadow_full  (shadow_full),
        .args_valid   (args_valid),
        .args_out     (args_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_at(input int k);
        return args_out[k*32 +: 32];
    endfunction

    // elem[j] = j + off
    task automatic set_word(input int off);
        for (int j = 0; j < 64; j++) buf_dout[j*16 +: 16] = 16'(j + off);
    endtask

    task automatic do_read(input logic m, input logic [7:0] start, input logic [7:0] size);
        buf_rd    = 1'b1;
        mode      = m;
        reg_start = start;
        reg_size  = size;
    endtask

    task automatic refresh_pulse();
        args_refresh = 1'b1;
        tick();
        args_refresh = 1'b0;
    endtask

    task automatic swap_now();
        args_swap = 1'b1;
        tick();
        check("swap_ack", {31'd0, args_swap_ack}, 32'd1);
        args_swap = 1'b0;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b0;
        mode         = 1'b0;
        args_refresh = 1'b0;
        buf_rd       = 1'b0;
        reg_start    = '0;
        reg_size     = '0;
        buf_dout     = '0;
        args_swap    = 1'b0;
        tick();
        tick();
        check("rst_ack",   {31'd0, args_swap_ack}, 32'd0);
        check("rst_done",  {31'd0, load_done},     32'd0);
        check("rst_full",  {31'd0, shadow_full},   32'd0);
        check("rst_valid", {31'd0, args_valid},    32'd0);
        check("rst_out",   {31'd0, |args_out},     32'd0);
        reset = 1'b1;
        tick();

        // Mode 0, one full read, elem[j] = j+1
        set_word(1);
        refresh_pulse();
        do_read(1'b0, 8'd0, 8'd63);
        tick();
        buf_rd = 1'b0;
        check("m0_done_t1", {31'd0, load_done}, 32'd0);
        tick();
        check("m0_done_t2", {31'd0, load_done},   32'd1);
        check("m0_full",    {31'd0, shadow_full}, 32'd1);
        tick();
        check("m0_done_t3", {31'd0, load_done}, 32'd0);
        swap_now();
        check("m0_valid",    {31'd0, args_valid},  32'd1);
        check("m0_full_clr", {31'd0, shadow_full}, 32'd0);
        tick();
        check("m0_ack_pulse", {31'd0, args_swap_ack}, 32'd0);
        check("m0_reg0",  reg_at(0),  32'd1);
        check("m0_reg5",  reg_at(5),  32'd6);
        check("m0_reg63", reg_at(63), 32'd64);

        // Mode 1, two back-to-back reads, elem[j] = j
        set_word(0);
        refresh_pulse();
        do_read(1'b1, 8'd0, 8'd31);
        tick();
        do_read(1'b1, 8'd32, 8'd31);
        tick();
        buf_rd = 1'b0;
        check("m1_done_first", {31'd0, load_done}, 32'd0);
        tick();
        check("m1_done_second", {31'd0, load_done}, 32'd1);
        swap_now();
        check("m1_reg0",  reg_at(0),  32'h0001_0000);
        check("m1_reg31", reg_at(31), 32'h003F_003E);
        check("m1_reg32", reg_at(32), 32'h0001_0000);
        check("m1_reg63", reg_at(63), 32'h003F_003E);

        // Partial mode-0 reads with src_base offset
        refresh_pulse();
        do_read(1'b0, 8'd0, 8'd9);
        tick();
        do_read(1'b0, 8'd10, 8'd53);
        tick();
        buf_rd = 1'b0;
        tick();
        check("pt_done", {31'd0, load_done}, 32'd1);
        swap_now();
        check("pt_reg9",  reg_at(9),  32'd9);
        check("pt_reg10", reg_at(10), 32'd10);
        check("pt_reg63", reg_at(63), 32'd63);
        // src_base must be back at 0: a single-reg read lands elem[0]
        set_word(100);
        do_read(1'b0, 8'd63, 8'd0);
        tick();
        buf_rd = 1'b0;
        tick();
        check("pt_wrap_done", {31'd0, load_done}, 32'd1);
        swap_now();
        check("pt_wrap_reg63", reg_at(63), 32'd100);
        check("pt_wrap_reg0",  reg_at(0),  32'd0);

        // Swap requested before the shadow bank is full
        args_swap = 1'b1;
        tick();
        check("nf_no_ack", {31'd0, args_swap_ack}, 32'd0);
        set_word(200);
        args_refresh = 1'b1;
        do_read(1'b0, 8'd0, 8'd63);
        tick();
        args_refresh = 1'b0;
        buf_rd       = 1'b0;
        check("nf_no_ack_t1", {31'd0, args_swap_ack}, 32'd0);
        tick();
        check("nf_full_t2",   {31'd0, shadow_full},   32'd1);
        check("nf_no_ack_t2", {31'd0, args_swap_ack}, 32'd0);
        check("nf_keep_out",  reg_at(63), 32'd100);
        tick();
        check("nf_ack_t3", {31'd0, args_swap_ack}, 32'd1);
        args_swap = 1'b0;
        check("nf_reg0",  reg_at(0),  32'd200);
        check("nf_reg63", reg_at(63), 32'd263);

        // Refresh between two reads, then swap+refresh together
        set_word(1);
        refresh_pulse();
        do_read(1'b0, 8'd0, 8'd31);
        tick();
        buf_rd = 1'b0;
        tick();
        check("rf_done_first", {31'd0, load_done}, 32'd0);
        refresh_pulse();
        check("rf_done_idle", {31'd0, load_done}, 32'd0);
        set_word(300);
        do_read(1'b0, 8'd32, 8'd31);
        tick();
        buf_rd = 1'b0;
        tick();
        check("rf_done_second", {31'd0, load_done},   32'd1);
        check("rf_full",        {31'd0, shadow_full}, 32'd1);
        args_swap    = 1'b1;
        args_refresh = 1'b1;
        tick();
        args_swap    = 1'b0;
        args_refresh = 1'b0;
        check("sr_ack",   {31'd0, args_swap_ack}, 32'd1);
        check("sr_full",  {31'd0, shadow_full},   32'd0);
        check("sr_reg0",  reg_at(0),  32'd1);
        check("sr_reg31", reg_at(31), 32'd32);
        check("sr_reg32", reg_at(32), 32'd300);

        // Asynchronous reset with a read in flight
        set_word(5);
        do_read(1'b0, 8'd0, 8'd63);
        tick();
        buf_rd = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("ar_valid", {31'd0, args_valid},    32'd0);
        check("ar_out",   {31'd0, |args_out},     32'd0);
        check("ar_full",  {31'd0, shadow_full},   32'd0);
        check("ar_ack",   {31'd0, args_swap_ack}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("ar_no_done", {31'd0, load_done},   32'd0);
        check("ar_no_full", {31'd0, shadow_full}, 32'd0);
        args_swap = 1'b1;
        tick();
        tick();
        args_swap = 1'b0;
        check("ar_no_swap", {31'd0, args_swap_ack}, 32'd0);
        check("ar_out_post", {31'd0, |args_out}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
